// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline stage slice.
//   - default widths for datapath, control bundle and performance counters
//   - skid-buffer occupancy encoding (EMPTY / ONE / TWO)
//   - control-flag bundle layout carried alongside each stage's payload
package pipe_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CTRL_W_DEF = 24;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  // Control bundle layout; an all-zero bundle is a harmless bubble.
  typedef struct packed {
    logic [14:0] opcode;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        halt;
  } ctrl_bundle_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: saturating up-counter.
//   i_clk  - clock
//   i_rst  - synchronous active-high reset to zero
//   i_inc  - increment request for this cycle
//   o_cnt  - current count; sticks at all-ones
module pipe_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: two-entry skid-buffered pipeline stage.
//   i_clk, i_rst              - clock, synchronous active-high reset
//   i_step                    - debug step enable; low freezes everything
//   i_flush                   - drop all held entries and any incoming beat
//   i_up_valid/o_up_ready,
//   i_up_data/i_up_ctrl       - upstream handshake
//   o_dn_valid/i_dn_ready,
//   o_dn_data/o_dn_ctrl       - downstream handshake; payload zero when idle
//   o_stall_cnt/o_bubble_cnt  - saturating perf counters, only when the
//                               PIPE_STAGE_PERF_EN macro is defined
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_step,
  input  logic              i_flush,
  input  logic              i_up_valid,
  output logic              o_up_ready,
  input  logic [DATA_W-1:0] i_up_data,
  input  logic [CTRL_W-1:0] i_up_ctrl,
  output logic              o_dn_valid,
  input  logic              i_dn_ready,
  output logic [DATA_W-1:0] o_dn_data,
  output logic [CTRL_W-1:0] o_dn_ctrl
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_bubble_cnt
`endif
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic              up_ready_q, up_ready_d;
  logic              dn_valid;
  logic              up_fire, dn_fire;

  assign dn_valid = (state_q != ST_EMPTY);
  assign up_fire  = i_step & i_up_valid & up_ready_q;
  assign dn_fire  = i_step & dn_valid & i_dn_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (i_step && i_flush) begin
      state_d     = ST_EMPTY;
      main_data_d = '0;
      main_ctrl_d = '0;
      skid_data_d = '0;
      skid_ctrl_d = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (up_fire) begin
            state_d     = ST_ONE;
            main_data_d = i_up_data;
            main_ctrl_d = i_up_ctrl;
          end
        end
        ST_ONE: begin
          if (up_fire && dn_fire) begin
            main_data_d = i_up_data;
            main_ctrl_d = i_up_ctrl;
          end else if (up_fire) begin
            state_d     = ST_TWO;
            skid_data_d = i_up_data;
            skid_ctrl_d = i_up_ctrl;
          end else if (dn_fire) begin
            state_d     = ST_EMPTY;
            main_data_d = '0;
            main_ctrl_d = '0;
          end
        end
        ST_TWO: begin
          // up_ready is low in TWO, so only a drain can happen here.
          if (dn_fire) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            skid_data_d = '0;
            skid_ctrl_d = '0;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
    // Ready is registered from the next state so i_dn_ready never reaches it combinationally.
    up_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      up_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      up_ready_q  <= up_ready_d;
    end
  end

  assign o_up_ready = up_ready_q;
  assign o_dn_valid = dn_valid;
  assign o_dn_data  = dn_valid ? main_data_q : '0;
  assign o_dn_ctrl  = dn_valid ? main_ctrl_q : '0;

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (i_step & dn_valid & ~i_dn_ready),
    .o_cnt (o_stall_cnt)
  );

  pipe_sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (i_step & ~dn_valid),
    .o_cnt (o_bubble_cnt)
  );
`else
  logic [CNT_W-1:0] cnt_w_unused;
  assign cnt_w_unused = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  localparam int unsigned CNT_MAX = 15;

  logic        clk = 1'b0;
  logic        rst, step, flush, up_valid, dn_ready;
  logic [31:0] up_data;
  logic [23:0] up_ctrl;
  logic        up_ready, dn_valid;
  logic [31:0] dn_data;
  logic [23:0] dn_ctrl;
`ifdef PIPE_STAGE_PERF_EN
  logic [3:0]  stall_cnt, bubble_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_stall  = 0;
  int exp_bubble = 0;
  bit cur_valid  = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W (32),
    .CTRL_W (24),
    .CNT_W  (4)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_step       (step),
    .i_flush      (flush),
    .i_up_valid   (up_valid),
    .o_up_ready   (up_ready),
    .i_up_data    (up_data),
    .i_up_ctrl    (up_ctrl),
    .o_dn_valid   (dn_valid),
    .i_dn_ready   (dn_ready),
    .o_dn_data    (dn_data),
    .o_dn_ctrl    (dn_ctrl)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .o_stall_cnt  (stall_cnt),
    .o_bubble_cnt (bubble_cnt)
`endif
  );

  typedef struct packed {
    logic        step;
    logic        flush;
    logic        up_valid;
    logic [31:0] data;
    logic [23:0] ctrl;
    logic        dn_ready;
    logic        e_valid;
    logic [31:0] e_data;
    logic [23:0] e_ctrl;
    logic        e_ready;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Update the counter model from the pre-edge state, then advance one cycle.
  task automatic tick();
    if (rst) begin
      exp_stall  = 0;
      exp_bubble = 0;
    end else if (step) begin
      if (cur_valid && !dn_ready && exp_stall < CNT_MAX) exp_stall++;
      if (!cur_valid && exp_bubble < CNT_MAX) exp_bubble++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input bit v, input logic [31:0] d,
                            input logic [23:0] c, input bit r);
    chk({nm, ".valid"}, 64'(dn_valid), 64'(v));
    chk({nm, ".data"},  64'(dn_data),  64'(d));
    chk({nm, ".ctrl"},  64'(dn_ctrl),  64'(c));
    chk({nm, ".ready"}, 64'(up_ready), 64'(r));
`ifdef PIPE_STAGE_PERF_EN
    chk({nm, ".stall_cnt"},  64'(stall_cnt),  64'(exp_stall));
    chk({nm, ".bubble_cnt"}, 64'(bubble_cnt), 64'(exp_bubble));
`endif
    cur_valid = v;
  endtask

  task automatic drive(input bit s, input bit f, input bit uv, input logic [31:0] d,
                       input logic [23:0] c, input bit dr);
    step = s; flush = f; up_valid = uv; up_data = d; up_ctrl = c; dn_ready = dr;
  endtask

  initial begin
    //        step flush uv  data           ctrl        dr   e_v  e_data         e_ctrl      e_rdy
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'hA5A5A5A5, 24'h000001, 1'b1, 1'b1, 32'hA5A5A5A5, 24'h000001, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        24'h0,      1'b1, 1'b0, 32'h0,        24'h0,      1'b1};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h1,        24'h000011, 1'b0, 1'b1, 32'h1,        24'h000011, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h2,        24'h000022, 1'b0, 1'b1, 32'h1,        24'h000011, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h99,       24'h000099, 1'b0, 1'b1, 32'h1,        24'h000011, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,        24'h0,      1'b1, 1'b1, 32'h2,        24'h000022, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,        24'h0,      1'b1, 1'b0, 32'h0,        24'h0,      1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h10,       24'h000100, 1'b1, 1'b1, 32'h10,       24'h000100, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h20,       24'h000200, 1'b1, 1'b1, 32'h20,       24'h000200, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'h30,       24'h000300, 1'b0, 1'b1, 32'h20,       24'h000200, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 32'h3,        24'h000003, 1'b0, 1'b0, 32'h0,        24'h0,      1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h0,        24'h0,      1'b1, 1'b0, 32'h0,        24'h0,      1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h44,       24'h000044, 1'b1, 1'b0, 32'h0,        24'h0,      1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 32'h45,       24'h000045, 1'b1, 1'b0, 32'h0,        24'h0,      1'b1};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 32'h55,       24'h000055, 1'b0, 1'b1, 32'h55,       24'h000055, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 32'h66,       24'h000066, 1'b1, 1'b1, 32'h55,       24'h000055, 1'b1};

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 24'h0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    expect_out("reset", 1'b0, 32'h0, 24'h0, 1'b1);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].step, vecs[i].flush, vecs[i].up_valid, vecs[i].data,
            vecs[i].ctrl, vecs[i].dn_ready);
      tick();
      expect_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data,
                 vecs[i].e_ctrl, vecs[i].e_ready);
    end

    // Fill to TWO (0x55 in MAIN, 0x77 in SKID), then freeze with valid and ready high.
    drive(1'b1, 1'b0, 1'b1, 32'h77, 24'h000077, 1'b0);
    tick();
    expect_out("fill_two", 1'b1, 32'h55, 24'h000055, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h88, 24'h000088, 1'b1);
      tick();
      expect_out($sformatf("freeze%0d", i), 1'b1, 32'h55, 24'h000055, 1'b0);
    end

    // Reset while in TWO, with step low; then a fresh beat passes as from EMPTY.
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 32'h99, 24'h000099, 1'b1);
    tick();
    rst = 1'b0;
    expect_out("rst_in_two", 1'b0, 32'h0, 24'h0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 32'h7, 24'h000007, 1'b1);
    tick();
    expect_out("post_rst_beat", 1'b1, 32'h7, 24'h000007, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 24'h0, 1'b1);
    tick();
    expect_out("post_rst_drain", 1'b0, 32'h0, 24'h0, 1'b1);

    // 20 stepped empty cycles drive the 4-bit bubble counter into saturation.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 24'h0, 1'b1);
      tick();
    end
    expect_out("idle20", 1'b0, 32'h0, 24'h0, 1'b1);
`ifdef PIPE_STAGE_PERF_EN
    chk("bubble_saturated", 64'(bubble_cnt), 64'hF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
